// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding, buffer entry layout and PC helpers.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs between fetch and decode.
// Registered storage; flush clears pointers and count in one cycle.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fifo_entry_t            wdata,
  output fifo_entry_t            rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and instruction memory requester with a small return buffer.
// One request in flight; branch redirects flush and drop wrong-path data.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemValid,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state;
  logic [31:0] fetch_pc;
  logic        drop;
  logic [31:0] target;
  logic [31:0] pc_nxt;
  logic        push;
  logic        pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic        space_after;
  logic        empty;
  logic        full;
  fifo_entry_t wdata;
  fifo_entry_t head;

  assign target = align_pc(BranchTarget);
  assign pc_nxt = PCSrc ? target : fetch_pc;

  assign push = (state == S_WAIT) && IMemValid
             && !drop && !PCSrc && !full;
  assign pop  = InstrValid && InstrReady && !PCSrc;

  // IMemAddr holds the in-flight address through S_WAIT
  assign wdata.pc    = IMemAddr;
  assign wdata.instr = IMemRdata;

  always_comb begin
    count_after = count;
    if (PCSrc) begin
      count_after = '0;
    end else if (push && !pop) begin
      count_after = count + CW'(1);
    end else if (pop && !push) begin
      count_after = count - CW'(1);
    end
  end

  assign space_after = (count_after < CW'(FIFO_DEPTH));

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Rst),
    .push (push),
    .pop  (pop),
    .flush(PCSrc),
    .wdata(wdata),
    .rdata(head),
    .count(count),
    .empty(empty),
    .full (full)
  );

  assign InstrValid  = !empty;
  assign Instruction = empty ? NOP_INSTR : head.instr;
  assign InstrPC     = empty ? 32'h0 : head.pc;

  // drop set in S_REQ also marks that fetch_pc already holds the target
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      IMemReq  <= 1'b0;
      IMemAddr <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      if (PCSrc) begin
        fetch_pc <= target;
      end
      unique case (state)
        S_IDLE: begin
          if (PCSrc || count < CW'(FIFO_DEPTH)) begin
            state    <= S_REQ;
            IMemReq  <= 1'b1;
            IMemAddr <= pc_nxt;
          end
        end
        S_REQ: begin
          if (IMemGnt) begin
            state   <= S_WAIT;
            IMemReq <= 1'b0;
            if (PCSrc) begin
              drop <= 1'b1;
            end else if (!drop) begin
              fetch_pc <= fetch_pc + PC_INC;
            end
          end else if (PCSrc) begin
            drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (IMemValid) begin
            drop <= 1'b0;
            if (space_after) begin
              state    <= S_REQ;
              IMemReq  <= 1'b1;
              IMemAddr <= pc_nxt;
            end else begin
              state <= S_IDLE;
            end
          end else if (PCSrc) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          IMemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model plus request
// and delivery scoreboards fed by directed stimulus.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemValid;
  logic [31:0] IMemRdata;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic [63:0] exp_out[$];
  logic [31:0] exp_req[$];
  logic [63:0] oe;
  logic [31:0] re;
  logic [31:0] ma;

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(2)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemGnt     (IMemGnt),
    .IMemValid   (IMemValid),
    .IMemRdata   (IMemRdata),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .PCSrc       (PCSrc),
    .BranchTarget(BranchTarget)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'h2002_0005 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", n, a, x);
    end
  endtask

  task automatic rst_check(input string n);
    chk1({n, "_req"}, IMemReq, 1'b0);
    chk({n, "_addr"}, IMemAddr, 32'h0);
    chk1({n, "_valid"}, InstrValid, 1'b0);
    chk({n, "_instr"}, Instruction, 32'h0);
    chk({n, "_pc"}, InstrPC, 32'h0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_grant(input string n);
    int k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!(IMemReq && IMemGnt) && k < 20);
    chk1(n, IMemReq && IMemGnt, 1'b1);
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string n);
    int k = 0;
    InstrReady = 1'b1;
    do begin
      @(negedge Clk);
      k++;
    end while (InstrValid && k < 10);
    chk1(n, InstrValid, 1'b0);
    @(posedge Clk);
    #1;
    InstrReady = 1'b0;
  endtask

  task automatic want(input logic [31:0] pc);
    exp_out.push_back({pc, mw(pc)});
  endtask

  // memory: grant sampled mid-cycle, data returned lat cycles later
  initial begin
    IMemValid = 1'b0;
    IMemRdata = 32'h0;
    forever begin
      @(negedge Clk);
      if (!Rst && IMemReq && IMemGnt) begin
        ma = IMemAddr;
        @(posedge Clk);
        for (int i = 1; i < lat; i++) @(posedge Clk);
        #1;
        IMemValid = 1'b1;
        IMemRdata = mw(ma);
        @(posedge Clk);
        #1;
        IMemValid = 1'b0;
        IMemRdata = 32'h0;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst && IMemReq && IMemGnt) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected got=%h exp=none", IMemAddr);
      end else begin
        re = exp_req.pop_front();
        if (IMemAddr !== re) begin
          errors++;
          $display("FAIL req_addr got=%h exp=%h", IMemAddr, re);
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst && InstrValid && InstrReady && !PCSrc) begin
      checks++;
      if (exp_out.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h_%h exp=none",
                 InstrPC, Instruction);
      end else begin
        oe = exp_out.pop_front();
        if ({InstrPC, Instruction} !== oe) begin
          errors++;
          $display("FAIL out_entry got=%h_%h exp=%h_%h",
                   InstrPC, Instruction, oe[63:32], oe[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    Rst          = 1'b1;
    IMemGnt      = 1'b1;
    InstrReady   = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = 32'h0;
    lat          = 1;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    rst_check("rst");
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);

    // first fetch latency
    @(negedge Clk);
    chk1("t1_req", IMemReq, 1'b1);
    chk("t1_addr", IMemAddr, 32'h0);
    @(negedge Clk);
    chk1("t1_c2_valid", InstrValid, 1'b0);
    @(negedge Clk);
    chk1("t1_valid", InstrValid, 1'b1);
    chk("t1_instr", Instruction, 32'h2002_0005);
    chk("t1_pc", InstrPC, 32'h0);

    // buffer full, fetch stalls
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      chk1("t2_noreq", IMemReq, 1'b0);
      @(negedge Clk);
    end
    chk1("t2_full_valid", InstrValid, 1'b1);
    chk("t2_full_pc", InstrPC, 32'h0);

    lat = 2;
    want(32'h0);
    exp_req.push_back(32'h8);
    @(posedge Clk);
    #1;
    InstrReady = 1'b1;
    @(posedge Clk);
    #1;
    InstrReady = 1'b0;
    wait_grant("t2_resume");

    // redirect while waiting for PC 8
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    PCSrc        = 1'b1;
    BranchTarget = 32'h0000_0103;
    @(negedge Clk);
    chk("t3_pre_pc", InstrPC, 32'h4);
    @(posedge Clk);
    #1;
    PCSrc = 1'b0;
    @(negedge Clk);
    chk1("t3_flush", InstrValid, 1'b0);
    settle(16);
    IMemGnt = 1'b0;
    want(32'h100);
    want(32'h104);
    drain("t3_drain");

    // redirect while request is stalled without grant
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h40);
    exp_req.push_back(32'h44);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      PCSrc        = (i == 2);
      BranchTarget = 32'h40;
      @(negedge Clk);
      chk1("t4_req", IMemReq, 1'b1);
      chk("t4_addr", IMemAddr, 32'h108);
    end
    @(posedge Clk);
    #1;
    PCSrc   = 1'b0;
    lat     = 1;
    IMemGnt = 1'b1;
    settle(16);
    IMemGnt = 1'b0;
    want(32'h40);
    want(32'h44);
    drain("t4_drain");

    // redirect coincides with returned data
    exp_req.push_back(32'h48);
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    IMemGnt = 1'b1;
    wait_grant("t5_grant");
    PCSrc        = 1'b1;
    BranchTarget = 32'h200;
    @(posedge Clk);
    #1;
    PCSrc = 1'b0;
    @(negedge Clk);
    chk1("t5a_valid", InstrValid, 1'b0);
    chk("t5a_addr", IMemAddr, 32'h200);
    settle(16);

    // redirect coincides with a pop
    want(32'h200);
    exp_req.push_back(32'h300);
    exp_req.push_back(32'h304);
    InstrReady = 1'b1;
    @(posedge Clk);
    #1;
    PCSrc        = 1'b1;
    BranchTarget = 32'h300;
    @(posedge Clk);
    #1;
    PCSrc      = 1'b0;
    InstrReady = 1'b0;
    @(negedge Clk);
    chk1("t5b_valid", InstrValid, 1'b0);
    chk1("t5b_req", IMemReq, 1'b1);
    chk("t5b_addr", IMemAddr, 32'h300);
    settle(16);

    // top-of-memory wrap
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    PCSrc        = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    @(posedge Clk);
    #1;
    PCSrc = 1'b0;
    settle(16);
    IMemGnt = 1'b0;
    want(32'hFFFF_FFFC);
    want(32'h0);
    drain("t6_drain");

    // reset during S_WAIT, late response must vanish
    lat = 2;
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    IMemGnt = 1'b1;
    wait_grant("t6_grant");
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    rst_check("t6_rst");
    settle(16);
    IMemGnt = 1'b0;
    want(32'h0);
    want(32'h4);
    drain("t6_final");

    chk("out_q_empty", 32'(exp_out.size()), 32'h0);
    chk("req_q_empty", 32'(exp_req.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer end of the instruction/branch interface consumed by Controller, ALUControl, ALU32Bit and Branch.
- Owns the PC and issues word reads to instruction memory over a req/gnt/valid handshake.
- Buffers returned words in a small FIFO and presents them downstream with a valid/ready handshake.
- Takes the PCSrc/branch-target redirect back from the Branch logic and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- IMemReq  out  1  read request; held until granted.
- IMemAddr  out  32  word address of the request; stable while IMemReq && !IMemGnt.
- IMemGnt  in  1  request accepted this cycle.
- IMemValid  in  1  read data returned this cycle (≥1 cycle after grant).
- IMemRdata  in  32  returned instruction word.
- Instruction  out  32  FIFO head; 32'h0 (NOP) when empty.
- InstrPC  out  32  PC of Instruction; 0 when empty.
- InstrValid  out  1  FIFO non-empty.
- InstrReady  in  1  consumer pops head when InstrValid && InstrReady.
- PCSrc  in  1  one-cycle redirect strobe.
- BranchTarget  in  32  redirect address; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset values: IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instruction=0, InstrPC=0, FIFO count=0, drop flag=0, state=S_IDLE, fetch_pc=RESET_PC.
- Reset mid-operation abandons any in-flight request; a response arriving after reset is ignored (the drop flag is not needed, because state=S_IDLE).
- FSM states:
  - S_IDLE: go to S_REQ when count + 0 < FIFO_DEPTH.
  - S_REQ: IMemReq=1, IMemAddr=fetch_pc. On IMemGnt: go to S_WAIT and set fetch_pc += 4 (wraps 0xFFFF_FFFC→0).
  - S_WAIT: IMemReq=0. On IMemValid: push {fetch address, IMemRdata} unless drop=1; clear drop; go to S_REQ if space remains after this cycle's push/pop, else S_IDLE.
- Exactly one request outstanding at any time, so peak throughput is 1 instruction per 2 cycles with 1-cycle memory latency.
- Space rule: a request issues only if count < FIFO_DEPTH, so a response can never find the FIFO full.
- FIFO: registered. A push is visible on InstrValid the next cycle. Push and pop in the same cycle leave count unchanged.
- Latency: with IMemGnt in the first S_REQ cycle and IMemValid one cycle later, InstrValid rises 3 cycles after the Rst-low edge.
- Redirect, PCSrc=1:
  - Next cycle: FIFO empty (count=0, InstrValid=0).
  - fetch_pc becomes {BranchTarget[31:2],2'b00}.
  - In S_WAIT: drop=1, and the pending response is discarded.
  - In S_REQ not yet granted: request stays asserted with the old address until granted, then drop=1 and the response is discarded. The next request uses the target.
  - In S_REQ granted the same cycle: same as S_WAIT. fetch_pc takes the target, not old+4.
  - In S_IDLE: go to S_REQ next cycle with the target.
- Simultaneous events:
  - PCSrc + IMemValid: data dropped.
  - PCSrc + pop: flush wins; the pop has no further effect.
  - PCSrc on consecutive cycles: the last target wins; at most one response is dropped per outstanding request.

Decomposition:
- Shared package ifu_pkg:
  - State encoding S_IDLE/S_REQ/S_WAIT.
  - NOP_INSTR = 32'h0.
  - Default RESET_PC.
  - PC_INC = 4.
- One sub-module, fetch_fifo: parameterised depth, 64-bit entries {pc,instr}, push/pop/flush, count/empty/full.

Test Plan:
1. Reset, IMemGnt tied 1, 1-cycle return of 32'h2002_0005 → IMemAddr=0 in cycle 1; InstrValid=1, Instruction=32'h2002_0005, InstrPC=0 in cycle 3.
2. InstrReady=0, continuous memory → exactly 2 entries fetched (PC 0, 4), IMemReq stays 0 afterwards. Raise InstrReady → fetch resumes at PC 8.
3. PCSrc=1 with BranchTarget=32'h0000_0103 while in S_WAIT for PC 8 → FIFO emptied, the PC 8 response is dropped, next IMemAddr=32'h0000_0100, next delivered InstrPC=0x100.
4. IMemGnt held 0 for 5 cycles with PCSrc pulsed mid-way (target 0x40) → IMemAddr stays at the old value until grant, that response is dropped, next request is 0x40.
5. PCSrc and IMemValid in the same cycle, and PCSrc with a pop in the same cycle → no entry pushed, InstrValid=0 next cycle.
6. Redirect to 32'hFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000. Rst asserted during S_WAIT → all outputs at reset values next cycle, and the late IMemValid is ignored.
